multi_timer: RTL and testbench

//   Parametrised timer/counter with prescaler, up/down/up-down counting, one-shot mode
//   and NUM_CMP compare channels, each with a match pulse and PWM output.

---
 rtl/multi_timer.sv | 161 ++++++++++++++++
 tb/tb_multi_timer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// Prescaled timer/counter with up, down and up-down counting, one-shot stop and
// NUM_CMP compare channels. Period and compare settings are shadowed and change only at period boundaries.
module multi_timer #(
  parameter int WIDTH   = 32,
  parameter int NUM_CMP = 4,
  parameter int PRESC_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic                     one_shot,
  input  logic [PRESC_W-1:0]       prescale,
  input  logic [WIDTH-1:0]         top_value,
  input  logic [NUM_CMP*WIDTH-1:0] cmp_value,
  output logic [WIDTH-1:0]         counter,
  output logic [NUM_CMP-1:0]       match,
  output logic [NUM_CMP-1:0]       pwm,
  output logic                     ovf,
  output logic                     running
);

  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_UPDN = 2'b10;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]               mode_sh;
  logic [PRESC_W-1:0]       prescale_sh;
  logic [WIDTH-1:0]         top_sh;
  logic [NUM_CMP*WIDTH-1:0] cmp_sh;
  logic [PRESC_W-1:0]       presc_cnt;
  logic                     dir_down;
  logic                     en_q;

  logic                     start;
  logic                     tick;
  logic                     wrap;
  logic                     update;
  logic                     dir_nxt;
  logic [WIDTH-1:0]         cnt_nxt;
  logic [WIDTH-1:0]         start_val;
  logic [WIDTH-1:0]         ref_val;
  logic [NUM_CMP-1:0]       match_nxt;
  logic [NUM_CMP-1:0]       pwm_nxt;

  always_comb begin
    start     = enable & ~en_q & ~running;
    tick      = (presc_cnt == prescale_sh);
    start_val = (mode == MODE_DOWN) ? top_value : '0;
    cnt_nxt   = counter;
    dir_nxt   = dir_down;
    wrap      = 1'b0;
    case (mode_sh)
      MODE_DOWN: begin
        // reload uses the top being shadowed on this very edge
        if (counter == '0) begin
          cnt_nxt = top_value;
          wrap    = 1'b1;
        end else begin
          cnt_nxt = counter - ONE;
        end
      end
      MODE_UPDN: begin
        if (!dir_down) begin
          if (counter >= top_sh) begin
            if (top_sh == '0) begin
              cnt_nxt = '0;
              wrap    = 1'b1;
            end else begin
              cnt_nxt = counter - ONE;
              dir_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = counter + ONE;
          end
        end else if (counter <= ONE) begin
          cnt_nxt = '0;
          wrap    = 1'b1;
          dir_nxt = 1'b0;
        end else begin
          cnt_nxt = counter - ONE;
        end
      end
      default: begin
        if (counter >= top_sh) begin
          cnt_nxt = '0;
          wrap    = 1'b1;
        end else begin
          cnt_nxt = counter + ONE;
        end
      end
    endcase
    update  = start | (enable & running & tick & wrap);
    ref_val = start ? start_val : cnt_nxt;
    match_nxt = '0;
    pwm_nxt   = '0;
    // on start/update edges compare against the value being shadowed now
    for (int i = 0; i < NUM_CMP; i++) begin
      match_nxt[i] = update ? (ref_val == cmp_value[i*WIDTH +: WIDTH])
                            : (ref_val == cmp_sh[i*WIDTH +: WIDTH]);
      pwm_nxt[i]   = update ? (ref_val <  cmp_value[i*WIDTH +: WIDTH])
                            : (ref_val <  cmp_sh[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_sh     <= '0;
      prescale_sh <= '0;
      top_sh      <= '0;
      cmp_sh      <= '0;
      presc_cnt   <= '0;
      dir_down    <= 1'b0;
      en_q        <= 1'b0;
      counter     <= '0;
      match       <= '0;
      pwm         <= '0;
      ovf         <= 1'b0;
      running     <= 1'b0;
    end else begin
      en_q  <= enable;
      match <= '0;
      ovf   <= 1'b0;
      if (update) begin
        mode_sh     <= mode;
        prescale_sh <= prescale;
        top_sh      <= top_value;
        cmp_sh      <= cmp_value;
      end
      if (!enable) begin
        running   <= 1'b0;
        presc_cnt <= '0;
        pwm       <= '0;
      end else if (start) begin
        running   <= 1'b1;
        presc_cnt <= '0;
        counter   <= start_val;
        dir_down  <= 1'b0;
        match     <= match_nxt;
        pwm       <= pwm_nxt;
      end else if (running) begin
        if (tick) begin
          presc_cnt <= '0;
          counter   <= cnt_nxt;
          dir_down  <= dir_nxt;
          ovf       <= wrap;
          match     <= match_nxt;
          if (wrap && one_shot) begin
            running <= 1'b0;
            pwm     <= '0;
          end else begin
            pwm     <= pwm_nxt;
          end
        end else begin
          presc_cnt <= presc_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: a vector table for the per-clock behaviour of each
// counting mode, plus sequences for prescaling, shadow update and async reset.
module tb_multi_timer;

  localparam int W  = 8;
  localparam int NC = 2;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [1:0]    mode;
  logic          one_shot;
  logic [PW-1:0] prescale;
  logic [W-1:0]  top_value;
  logic [W-1:0]  cmp0, cmp1;
  logic [W-1:0]  counter;
  logic [NC-1:0] match;
  logic [NC-1:0] pwm;
  logic          ovf;
  logic          running;

  int n_checks = 0;
  int n_fail   = 0;

  multi_timer #(.WIDTH(W), .NUM_CMP(NC), .PRESC_W(PW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .mode      (mode),
    .one_shot  (one_shot),
    .prescale  (prescale),
    .top_value (top_value),
    .cmp_value ({cmp1, cmp0}),
    .counter   (counter),
    .match     (match),
    .pwm       (pwm),
    .ovf       (ovf),
    .running   (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [1:0]   md;
    logic         os;
    logic [PW-1:0] ps;
    logic [W-1:0] top;
    logic [W-1:0] c0;
    logic [W-1:0] c1;
    logic [W-1:0] e_cnt;
    logic [1:0]   e_match;
    logic [1:0]   e_pwm;
    logic         e_ovf;
    logic         e_run;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic [1:0] md, input logic os, input int top,
                     input int c0, input int c1, input int cnt, input logic [1:0] m,
                     input logic [1:0] p, input logic o, input logic r);
    vec_t v;
    v.en = en; v.md = md; v.os = os; v.ps = '0;
    v.top = W'(top); v.c0 = W'(c0); v.c1 = W'(c1);
    v.e_cnt = W'(cnt); v.e_match = m; v.e_pwm = p; v.e_ovf = o; v.e_run = r;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {18'd0, counter, match, pwm, ovf, running};
  endfunction

  initial begin
    logic [W-1:0] seq[12];
    bit found;

    reset_n = 1'b0; enable = 1'b0; mode = 2'b00; one_shot = 1'b0;
    prescale = '0; top_value = '0; cmp0 = '0; cmp1 = '0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", outs(), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    // up, top 9, cmp0 3, cmp1 12 (above top -> pwm1 always high)
    add(1,0,0,9,3,12, 0,2'b00,2'b11,0,1);
    add(1,0,0,9,3,12, 1,2'b00,2'b11,0,1);
    add(1,0,0,9,3,12, 2,2'b00,2'b11,0,1);
    add(1,0,0,9,3,12, 3,2'b01,2'b10,0,1);
    for (int c = 4; c <= 9; c++) add(1,0,0,9,3,12, c,2'b00,2'b10,0,1);
    add(1,0,0,9,3,12, 0,2'b00,2'b11,1,1);
    add(1,0,0,9,3,12, 1,2'b00,2'b11,0,1);
    add(1,0,0,9,3,12, 2,2'b00,2'b11,0,1);
    add(1,0,0,9,3,12, 3,2'b01,2'b10,0,1);
    // enable falls on a tick edge: counter must not advance
    add(0,0,0,9,3,12, 3,2'b00,2'b00,0,0);
    add(0,0,0,9,3,12, 3,2'b00,2'b00,0,0);
    // down, top 5, cmp0 3, cmp1 0
    add(1,1,0,5,3,0, 5,2'b00,2'b00,0,1);
    add(1,1,0,5,3,0, 4,2'b00,2'b00,0,1);
    add(1,1,0,5,3,0, 3,2'b01,2'b00,0,1);
    add(1,1,0,5,3,0, 2,2'b00,2'b01,0,1);
    add(1,1,0,5,3,0, 1,2'b00,2'b01,0,1);
    add(1,1,0,5,3,0, 0,2'b10,2'b01,0,1);
    add(1,1,0,5,3,0, 5,2'b00,2'b00,1,1);
    add(1,1,0,5,3,0, 4,2'b00,2'b00,0,1);
    add(0,1,0,5,3,0, 4,2'b00,2'b00,0,0);
    // up-down, top 4, cmp0 7, cmp1 2
    add(1,2,0,4,7,2, 0,2'b00,2'b11,0,1);
    add(1,2,0,4,7,2, 1,2'b00,2'b11,0,1);
    add(1,2,0,4,7,2, 2,2'b10,2'b01,0,1);
    add(1,2,0,4,7,2, 3,2'b00,2'b01,0,1);
    add(1,2,0,4,7,2, 4,2'b00,2'b01,0,1);
    add(1,2,0,4,7,2, 3,2'b00,2'b01,0,1);
    add(1,2,0,4,7,2, 2,2'b10,2'b01,0,1);
    add(1,2,0,4,7,2, 1,2'b00,2'b11,0,1);
    add(1,2,0,4,7,2, 0,2'b00,2'b11,1,1);
    add(1,2,0,4,7,2, 1,2'b00,2'b11,0,1);
    add(0,2,0,4,7,2, 1,2'b00,2'b00,0,0);
    // one-shot up, top 3, cmp0 2, cmp1 0
    add(1,0,1,3,2,0, 0,2'b10,2'b01,0,1);
    add(1,0,1,3,2,0, 1,2'b00,2'b01,0,1);
    add(1,0,1,3,2,0, 2,2'b01,2'b00,0,1);
    add(1,0,1,3,2,0, 3,2'b00,2'b00,0,1);
    add(1,0,1,3,2,0, 0,2'b10,2'b00,1,0);
    add(1,0,1,3,2,0, 0,2'b00,2'b00,0,0);
    add(1,0,1,3,2,0, 0,2'b00,2'b00,0,0);

    foreach (vecs[i]) begin
      enable = vecs[i].en; mode = vecs[i].md; one_shot = vecs[i].os;
      prescale = vecs[i].ps; top_value = vecs[i].top;
      cmp0 = vecs[i].c0; cmp1 = vecs[i].c1;
      step();
      check($sformatf("vec%0d", i), outs(),
            {18'd0, vecs[i].e_cnt, vecs[i].e_match, vecs[i].e_pwm, vecs[i].e_ovf, vecs[i].e_run});
    end

    // prescale 3: step every 4 clk, ovf every 40 clk, 1-clk match pulse
    enable = 1'b0; step();
    mode = 2'b00; one_shot = 1'b0; prescale = 4'd3; top_value = 8'd9; cmp0 = 8'd3; cmp1 = 8'd0;
    enable = 1'b1; step();
    check("presc_start", {counter, ovf}, {8'd0, 1'b0});
    for (int k = 1; k <= 80; k++) begin
      step();
      check($sformatf("presc_k%0d", k), {counter, match[0], ovf},
            {W'((k / 4) % 10), ((k % 4 == 0) && ((k / 4) % 10 == 3)), (k % 40 == 0)});
    end

    // shadow: lower top to 4 and raise cmp0 to 12 at counter 6
    enable = 1'b0; step();
    prescale = '0; top_value = 8'd9; cmp0 = 8'd3; cmp1 = 8'd0;
    enable = 1'b1; step();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (counter == 8'd6) found = 1'b1;
    end
    check("shadow_reach6", {31'd0, found}, 32'd1);
    top_value = 8'd4; cmp0 = 8'd12;
    seq = '{8'd7, 8'd8, 8'd9, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1, 8'd2, 8'd3};
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("shadow_k%0d", k), {counter, ovf, pwm[0], match[0]},
            {seq[k], (k == 3 || k == 8), (k >= 3), 1'b0});
    end

    // one-shot second run, async reset at counter 2
    enable = 1'b0; step();
    one_shot = 1'b1; top_value = 8'd3; cmp0 = 8'd3; cmp1 = 8'd0;
    enable = 1'b1;
    repeat (3) step();
    check("os_pre_reset", {counter, pwm, running}, {8'd2, 2'b01, 1'b1});
    #1 reset_n = 1'b0;
    #1 check("async_reset", outs(), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    enable = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
